// File: rtl/arbitro_barramento.sv
// Four-requester round-robin bus arbiter with registered one-hot grant and mux select.
// Optional grant timeout is compiled in with `define ARB_TIMEOUT_EN.
module arbitro_barramento #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] controle,
  output logic       ocupado,
  output logic       timeout
);

  // state | meaning
  // IDLE  | no grant active, arbitrate among pending requests
  // GRANT | one requester owns the bus until release (or timeout)
  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_next;
  logic [3:0] grant_next;
  logic [1:0] controle_next;
  logic [1:0] ptr, ptr_next;
  logic       timeout_next;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic       release_hit;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt, cnt_next;
`endif

  // Round-robin search starting just past the last winner.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign release_hit = done | ~req[controle];

  always_comb begin
    state_next    = state;
    grant_next    = grant;
    controle_next = controle;
    ptr_next      = ptr;
    timeout_next  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_next      = cnt;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_next    = GRANT;
          grant_next    = 4'b0001 << winner;
          controle_next = winner;
          ptr_next      = winner;
`ifdef ARB_TIMEOUT_EN
          cnt_next      = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (release_hit) begin
          state_next = IDLE;
          grant_next = 4'b0000;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt == CNT_LAST) begin
          state_next   = IDLE;
          grant_next   = 4'b0000;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt + 8'd1;
`endif
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      controle <= 2'b00;
      ocupado  <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= 2'd3;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      controle <= controle_next;
      ocupado  <= |grant_next;
      timeout  <= timeout_next;
      ptr      <= ptr_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt <= 8'd0;
    else          cnt <= cnt_next;
  end
`endif

endmodule

// File: tb/tb_arbitro_barramento.sv
// Directed self-checking bench for arbitro_barramento; outputs sampled on the falling edge.
// Timeout expectations follow whether ARB_TIMEOUT_EN is defined.
module tb_arbitro_barramento;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] controle;
  logic       ocupado;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  arbitro_barramento #(.TIMEOUT_CYCLES(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .controle(controle),
    .ocupado (ocupado),
    .timeout (timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst_grant", {4'b0, grant}, 8'h00);
    check("rst_controle", {6'b0, controle}, 8'h00);
    check("rst_ocupado", {7'b0, ocupado}, 8'h00);
    check("rst_timeout", {7'b0, timeout}, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  logic [3:0] seq031 [9];

  initial begin
    reset_n = 1'b0;
    req     = 4'b0000;
    done    = 1'b0;
    seq031  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();

    // Single requester, done pulse
    req = 4'b0001;
    step();
    check("r030_grant", {4'b0, grant}, 8'h01);
    check("r030_controle", {6'b0, controle}, 8'h00);
    check("r030_ocupado", {7'b0, ocupado}, 8'h01);
    done = 1'b1;
    step();
    check("r030_release", {4'b0, grant}, 8'h00);
    check("r030_ocupado0", {7'b0, ocupado}, 8'h00);
    done = 1'b1;
    req  = 4'b0000;
    step();
    check("idle_done_ignored", {4'b0, grant}, 8'h00);
    done = 1'b0;

    // Full rotation with done held high
    do_reset();
    req  = 4'b1111;
    done = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("r031_seq%0d", i), {4'b0, grant}, {4'b0, seq031[i]});
      check($sformatf("r031_ocup%0d", i), {7'b0, ocupado}, {7'b0, |seq031[i]});
    end
    done = 1'b0;
    req  = 4'b0000;
    step();
    check("r031_end", {4'b0, grant}, 8'h00);
    check("r031_ctl_kept", {6'b0, controle}, 8'h00);

    // Holder keeps bus while others request; ptr now 0
    req = 4'b0010;
    step();
    check("r032_grant1", {4'b0, grant}, 8'h02);
    check("r032_ctl1", {6'b0, controle}, 8'h01);
    req = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      step();
      check("r032_hold", {4'b0, grant}, 8'h02);
      check("r032_hold_ctl", {6'b0, controle}, 8'h01);
    end
    req = 4'b0100;
    step();
    check("r032_idle", {4'b0, grant}, 8'h00);
    check("r032_idle_ctl", {6'b0, controle}, 8'h01);
    step();
    check("r032_grant2", {4'b0, grant}, 8'h04);
    check("r032_ctl2", {6'b0, controle}, 8'h02);
    req = 4'b0000;
    step();
    check("r032_rel", {4'b0, grant}, 8'h00);

    // Async reset mid-grant; ptr=2 so search 3,0 picks 0
    req = 4'b0001;
    step();
    check("r033_grant0", {4'b0, grant}, 8'h01);
    #2;
    reset_n = 1'b0;
    #1;
    check("r033_async_grant", {4'b0, grant}, 8'h00);
    check("r033_async_ctl", {6'b0, controle}, 8'h00);
    check("r033_async_ocup", {7'b0, ocupado}, 8'h00);
    @(negedge clock);
    check("r033_held_grant", {4'b0, grant}, 8'h00);
    req     = 4'b1000;
    reset_n = 1'b1;
    step();
    check("r033_grant3", {4'b0, grant}, 8'h08);
    check("r033_ctl3", {6'b0, controle}, 8'h03);
    req = 4'b0000;
    step();

    // Long hold: timeout or unlimited grant
    do_reset();
    req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step();
      check("r034_hold", {4'b0, grant}, 8'h01);
      check("r034_no_to", {7'b0, timeout}, 8'h00);
    end
    step();
    check("r034_revoked", {4'b0, grant}, 8'h00);
    check("r034_pulse", {7'b0, timeout}, 8'h01);
    step();
    check("r034_next", {4'b0, grant}, 8'h02);
    check("r034_pulse_end", {7'b0, timeout}, 8'h00);
`else
    for (int i = 0; i < 300; i++) begin
      step();
      check("r035_hold", {4'b0, grant}, 8'h01);
      check("r035_no_to", {7'b0, timeout}, 8'h00);
    end
`endif
    req = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitro_barramento.md
ARBITRO_BARRAMENTO -- requirements
Module: arbitro_barramento

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum cycles one grant may last when the timeout is compiled in; legal range 2..255.
REQ-002 SHALL have port clock  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  4  request lines, bit i = requester i, level-sensitive.
REQ-005 SHALL have port done  input  1  current grant holder ends its transfer this cycle.
REQ-006 SHALL have port grant  output  4  one-hot grant, registered.
REQ-007 SHALL have port controle  output  2  binary index of the granted requester, drives the 4:1 32-bit data mux select.
REQ-008 SHALL have port ocupado  output  1  high while any grant is active.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-010 SHALL implement two states: IDLE (grant = 4'b0000) and GRANT (exactly one grant bit high).
REQ-011 In IDLE with req != 0, SHALL select the winner round-robin, searching from index ptr+1 upward mod 4; the winner appears on grant/controle at the next rising edge (latency 1 cycle), and the state goes to GRANT.
REQ-012 In IDLE with req == 0, SHALL stay in IDLE; grant stays 0.
REQ-013 ptr SHALL update to the winner's index when a grant is issued.
REQ-014 In GRANT, grant and controle SHALL stay constant until release.
REQ-015 A release occurs when done = 1, or when req[controle] = 0; on release, the next edge SHALL return to IDLE with grant = 0.
REQ-016 done = 1 and the holder dropping req in the same cycle SHALL count as a single release.
REQ-017 Back-to-back grants SHALL have exactly one IDLE cycle between them: release edge, then IDLE, then new grant.
REQ-018 done SHALL be ignored in IDLE.
REQ-019 Requests from non-holders during GRANT SHALL be ignored until IDLE.
REQ-020 controle SHALL keep the last granted index while in IDLE, so the mux output does not glitch.
REQ-021 ocupado SHALL equal |grant, registered with grant.
REQ-022 grant SHALL never have more than one bit set.

Reset
REQ-023 While reset_n = 0, regardless of clock: state = IDLE, grant = 4'b0000, controle = 2'b00, ocupado = 0, timeout = 0, ptr = 3, and the timeout counter = 0.
REQ-024 Reset asserted mid-grant SHALL drop grant immediately.
REQ-025 After reset, the first arbitration SHALL favour requester 0.

Configuration
REQ-026 With ARB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on grant issue and increment each GRANT cycle.
REQ-027 With ARB_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYCLES-1 without a release, the next edge SHALL force IDLE with grant = 0 and pulse timeout = 1 for one cycle.
REQ-028 With ARB_TIMEOUT_EN defined, ptr already points past the offender, so the offender gets lowest priority next.
REQ-029 Without ARB_TIMEOUT_EN, no counter SHALL be built, timeout SHALL be tied to 0, and a grant SHALL last until release.

Verification
REQ-030 Reset then req = 4'b0001 held -> grant = 4'b0001 and controle = 0 one edge later; done pulse -> grant = 0 next edge.
REQ-031 req = 4'b1111 held, done pulsed every GRANT cycle -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
REQ-032 Grant to 1, then req = 4'b0110 with done = 0 -> grant stays 0010 and controle stays 1 until req[1] drops; then IDLE, then grant = 0100.
REQ-033 reset_n pulled low mid-GRANT between edges -> grant = 0 and controle = 0 without a clock edge; after release, req = 4'b1000 -> grant 1000.
REQ-034 With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 4: req = 4'b0011 held, done = 0 -> grant 0001 for 4 cycles, timeout pulse, IDLE, then grant 0010.
REQ-035 Without ARB_TIMEOUT_EN: same stimulus as REQ-034 -> grant 0001 held 300 cycles, timeout stays 0.
